ebus_pi_dev: RTL and testbench
==============================

Name: ebus_pi_dev

Overview:
- Device-side EBUS interrupt requester feeding the PI board; one instance per EBUS I/O device.
- Collects internal device events into pending flags and raises one PI request line at the programmed PIA level.
- Answers the PI board's two-phase service cycle. Phase 1 is ID: it returns a one-hot physical-number bit. Phase 2 is VECTOR: it returns the interrupt function word. It then retires the served source.

Parameters:
NSRC, 4, number of interrupt sources (1..8)
PHY, 4'd8, EBUS physical device number (0..15)
VEC_BASE, 18'o000100, vector base address (used only with VECTOR_INTR_EN)

Ports:
CLK  in  1  PI-domain clock
RESET_L  in  1  asynchronous, active-low reset
dev_event_i  in  NSRC  one-cycle event pulses; bit 0 is highest priority
cono_stb_i  in  1  one-cycle CONO strobe
cono_pia_i  in  3  PIA to load on strobe
cono_en_i  in  1  request enable to load on strobe
cono_clr_i  in  NSRC  pending bits to clear on strobe
coni_o  out  NSRC+4  {pending[NSRC-1:0], en, pia[2:0]}
ebus_pi_o  out  7  request lines, index 1..7
ebus_demand_i  in  1  PI board demand
ebus_func_i  in  3  function code: 3'o1 = ID, 3'o2 = VECTOR, others ignored
ebus_lvl_i  in  3  PI level being serviced (ID phase)
ebus_sel_i  in  4  selected physical number (VECTOR phase)
ebus_data_o  out  36  EBUS data, bit 0 = MSB
ebus_data_oe_o  out  1  data drive enable
ebus_xfer_o  out  1  transfer acknowledge

Behaviour:
- Reset (RESET_L low, async) clears all outputs and state:
  - pending = 0, en = 0, pia = 0.
  - ebus_pi_o = 0, ebus_data_o = 0, ebus_data_oe_o = 0, ebus_xfer_o = 0.
  - FSM = IDLE.
  - A reset mid-cycle drops the drivers immediately.
- Pending flags:
  - pending[i] sets on dev_event_i[i].
  - It clears on a CONO strobe with cono_clr_i[i] set, or on a retire of source i.
  - When a set and a clear hit the same cycle, the set wins.
- CONO:
  - On cono_stb_i, pia and en load on the next edge.
  - pia = 0 disables the request.
- Request:
  - req = en & |pending & (pia != 0).
  - ebus_pi_o[pia] = req, registered, so it follows the cause by 1 cycle.
  - All other request lines are 0.
  - The line holds until every pending bit is clear.
- FSM states: IDLE, ID, VEC, REL.
  - IDLE -> ID when ebus_demand_i & func = ID & lvl == pia & req. Latch plvl = pia and psrc = lowest-index pending bit.
  - IDLE -> VEC when ebus_demand_i & func = VECTOR & sel == PHY & a snapshot is valid (ID seen since the last retire).
  - ID: drive ebus_data_o[PHY] = 1 (one-hot in bits 0..15, all other bits 0), with oe = 1 and xfer = 1. Go to REL.
  - VEC: drive the function word with oe = 1 and xfer = 1. Go to REL and mark retire pending.
  - REL: hold the drivers until ebus_demand_i = 0. Then drop oe, xfer and data in the same cycle. If retire is marked, clear pending[psrc] and invalidate the snapshot. Go to IDLE.
- Latency: demand sampled at edge N gives data, oe and xfer visible after edge N+1.
- A demand that does not match (wrong lvl, sel or func) is ignored. The block stays in IDLE with nothing driven.
- CONO during ID/VEC/REL:
  - A pia/en change takes effect on ebus_pi_o at once.
  - The snapshot (plvl, psrc) is kept and the service cycle completes.
  - A cono_clr of psrc before retire is harmless, because retire clears an already-clear bit.
- New events during service set pending normally. The request line stays asserted if any bit is still pending after retire.
- Function word without VECTOR_INTR_EN:
  - data[3:5] = 3'o1 (standard interrupt).
  - data[18:35] = 0.
  - All other bits 0.

Optional Feature:
- Macro VECTOR_INTR_EN.
- When defined:
  - data[3:5] = 3'o2 (vector interrupt).
  - data[18:35] = VEC_BASE + 2*psrc.
- When undefined: the standard word described above, and VEC_BASE is unused.

Decomposition:
- Shared package pi_dev_pkg holds:
  - Function-code constants: FN_ID = 3'o1, FN_VEC = 3'o2, IFW_STD = 3'o1, IFW_VEC = 3'o2.
  - The FSM state enum.
  - The function-word field position constants.
- One sub-module pi_src_prio: NSRC-wide lowest-index priority encoder with a valid flag, used for psrc.

Test Plan:
- Reset, then CONO pia = 3, en = 1, then dev_event_i[2] -> ebus_pi_o = 7'b0010000 (line 3) one cycle later, and coni_o shows pending = 4'b0100.
- ID demand with lvl = 3 -> after 1 cycle data[8] = 1, oe = 1, xfer = 1. Demand drops -> all three drop the same cycle. Repeat with lvl = 5 -> no response.
- Events on bits 1 and 3, then ID + VECTOR with sel = 8 -> psrc = 1. With VECTOR_INTR_EN: data[18:35] = 18'o000102 and data[3:5] = 2. Without it: data[3:5] = 1. After release pending = 4'b1000 and the line stays asserted.
- dev_event_i[0] and cono_clr_i[0] in the same cycle -> pending[0] = 1.
- RESET_L low while in VEC with oe = 1 -> oe, xfer, data and ebus_pi_o go to 0 asynchronously. After release the FSM is in IDLE and coni_o = 0.
- CONO pia = 0 during REL -> ebus_pi_o = 0 next cycle, the cycle still completes, and pending[psrc] clears.

Source files
------------

// File: rtl/pi_dev_pkg.sv
// Shared constants and types for the EBUS PI device-side interrupt requester.
// Bit positions in the function word use EBUS numbering (bit 0 = MSB).
package pi_dev_pkg;

   localparam logic [2:0] FN_ID   = 3'o1;
   localparam logic [2:0] FN_VEC  = 3'o2;
   localparam logic [2:0] IFW_STD = 3'o1;
   localparam logic [2:0] IFW_VEC = 3'o2;

   localparam int IFW_LO = 3;
   localparam int IFW_HI = 5;
   localparam int ADR_LO = 18;
   localparam int ADR_HI = 35;

   // Source index width covers the largest supported NSRC of 8.
   localparam int SRC_W = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ID,
      S_VEC,
      S_REL
   } state_t;

endpackage

// File: rtl/ebus_pi_dev_if.sv
// EBUS interrupt signals between the PI board (master) and one I/O device (slave).
// Request lines are indexed 1..7 and data bit 0 is the MSB, matching EBUS numbering.
interface ebus_pi_dev_if;

   logic [1:7]  ebus_pi_o;
   logic        ebus_demand_i;
   logic [2:0]  ebus_func_i;
   logic [2:0]  ebus_lvl_i;
   logic [3:0]  ebus_sel_i;
   logic [0:35] ebus_data_o;
   logic        ebus_data_oe_o;
   logic        ebus_xfer_o;

   modport slave (
      output ebus_pi_o,
      input  ebus_demand_i,
      input  ebus_func_i,
      input  ebus_lvl_i,
      input  ebus_sel_i,
      output ebus_data_o,
      output ebus_data_oe_o,
      output ebus_xfer_o
   );

   modport master (
      input  ebus_pi_o,
      output ebus_demand_i,
      output ebus_func_i,
      output ebus_lvl_i,
      output ebus_sel_i,
      input  ebus_data_o,
      input  ebus_data_oe_o,
      input  ebus_xfer_o
   );

endinterface

// File: rtl/pi_src_prio.sv
// Lowest-index-wins priority encoder over the pending interrupt sources.
module pi_src_prio
   import pi_dev_pkg::*;
#(
   parameter int NSRC = 4
) (
   input  logic [NSRC-1:0]  i_req,
   output logic             o_vld,
   output logic [SRC_W-1:0] o_idx
);

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment, otherwise synthesis infers a latch.
   always_comb begin
      o_vld = |i_req;
      o_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = SRC_W'(i);
      end
   end

endmodule

// File: rtl/ebus_pi_dev.sv
// EBUS device-side interrupt requester: pending flags, PIA request line, ID/VECTOR service.
// Define VECTOR_INTR_EN to answer VECTOR with a vector-interrupt word at VEC_BASE + 2*src.
module ebus_pi_dev
   import pi_dev_pkg::*;
#(
   parameter int          NSRC     = 4,
   parameter logic [3:0]  PHY      = 4'd8,
   parameter logic [17:0] VEC_BASE = 18'o000100
) (
   input  logic            CLK,
   input  logic            RESET_L,
   input  logic [NSRC-1:0] dev_event_i,
   input  logic            cono_stb_i,
   input  logic [2:0]      cono_pia_i,
   input  logic            cono_en_i,
   input  logic [NSRC-1:0] cono_clr_i,
   output logic [NSRC+3:0] coni_o,
   ebus_pi_dev_if.slave    ebus
);

`ifdef VECTOR_INTR_EN
   localparam bit VEC_MODE = 1'b1;
`else
   localparam bit VEC_MODE = 1'b0;
`endif
   localparam logic [2:0] IFW_CODE = VEC_MODE ? IFW_VEC : IFW_STD;

   state_t           r_state;
   state_t           w_state_n;
   logic [NSRC-1:0]  r_pend;
   logic             r_en;
   logic [2:0]       r_pia;
   logic [1:7]       r_pi;
   logic             r_snap_vld;
   logic [2:0]       r_plvl;
   logic [SRC_W-1:0] r_psrc;
   logic             r_retire;
   logic [0:35]      r_data;
   logic             r_oe;
   logic             r_xfer;

   logic             w_req;
   logic             w_prio_vld;
   logic [SRC_W-1:0] w_prio_idx;
   logic [1:7]       w_pi_n;
   logic [0:35]      w_id_word;
   logic [0:35]      w_fn_word;
   logic [0:35]      w_data_n;
   logic             w_drv_n;
   logic             w_latch;
   logic             w_arm_retire;
   logic             w_do_retire;
   logic [NSRC-1:0]  w_clr;

   pi_src_prio #(.NSRC(NSRC)) u_prio (
      .i_req (r_pend),
      .o_vld (w_prio_vld),
      .o_idx (w_prio_idx)
   );

   assign w_req = r_en & w_prio_vld & (r_pia != 3'd0);

   always_comb begin
      w_pi_n = '0;
      for (int k = 1; k <= 7; k++) begin
         w_pi_n[k] = w_req && (r_pia == 3'(k));
      end
   end

   always_comb begin
      w_id_word      = '0;
      w_id_word[PHY] = 1'b1;
      w_fn_word      = '0;
      w_fn_word[IFW_LO:IFW_HI] = IFW_CODE;
      w_fn_word[ADR_LO:ADR_HI] = VEC_MODE ? (VEC_BASE + {14'd0, r_psrc, 1'b0}) : 18'd0;
   end

   // Set wins over clear: events are OR-ed in after CONO and retire clears.
   always_comb begin
      w_clr = cono_stb_i ? cono_clr_i : '0;
      for (int i = 0; i < NSRC; i++) begin
         if (w_do_retire && (r_psrc == SRC_W'(i))) w_clr[i] = 1'b1;
      end
   end

   always_comb begin
      w_state_n    = r_state;
      w_data_n     = r_data;
      w_drv_n      = r_oe;
      w_latch      = 1'b0;
      w_arm_retire = 1'b0;
      w_do_retire  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ebus.ebus_demand_i && (ebus.ebus_func_i == FN_ID) &&
                (ebus.ebus_lvl_i == r_pia) && w_req) begin
               w_state_n = S_ID;
               w_latch   = 1'b1;
            end else if (ebus.ebus_demand_i && (ebus.ebus_func_i == FN_VEC) &&
                         (ebus.ebus_sel_i == PHY) && r_snap_vld) begin
               w_state_n = S_VEC;
            end
         end
         S_ID: begin
            // Stay silent if the PI board has already moved off the latched level.
            w_state_n = S_REL;
            if (ebus.ebus_lvl_i == r_plvl) begin
               w_data_n = w_id_word;
               w_drv_n  = 1'b1;
            end
         end
         S_VEC: begin
            w_state_n    = S_REL;
            w_data_n     = w_fn_word;
            w_drv_n      = 1'b1;
            w_arm_retire = 1'b1;
         end
         S_REL: begin
            if (!ebus.ebus_demand_i) begin
               w_state_n   = S_IDLE;
               w_data_n    = '0;
               w_drv_n     = 1'b0;
               w_do_retire = r_retire;
            end
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) r_state <= S_IDLE;
      else          r_state <= w_state_n;
   end

   // The bus drivers sit on the async reset so a reset mid-cycle releases EBUS at once.
   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         r_pend     <= '0;
         r_en       <= 1'b0;
         r_pia      <= 3'd0;
         r_pi       <= '0;
         r_snap_vld <= 1'b0;
         r_plvl     <= 3'd0;
         r_psrc     <= '0;
         r_retire   <= 1'b0;
         r_data     <= '0;
         r_oe       <= 1'b0;
         r_xfer     <= 1'b0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | dev_event_i;
         r_pi   <= w_pi_n;
         r_data <= w_data_n;
         r_oe   <= w_drv_n;
         r_xfer <= w_drv_n;
         if (cono_stb_i) begin
            r_pia <= cono_pia_i;
            r_en  <= cono_en_i;
         end
         if (w_latch) begin
            r_plvl     <= r_pia;
            r_psrc     <= w_prio_idx;
            r_snap_vld <= 1'b1;
         end else if (w_do_retire) begin
            r_snap_vld <= 1'b0;
         end
         if (w_arm_retire)     r_retire <= 1'b1;
         else if (w_do_retire) r_retire <= 1'b0;
      end
   end

   assign coni_o              = {r_pend, r_en, r_pia};
   assign ebus.ebus_pi_o      = r_pi;
   assign ebus.ebus_data_o    = r_data;
   assign ebus.ebus_data_oe_o = r_oe;
   assign ebus.ebus_xfer_o    = r_xfer;

endmodule

// File: tb/tb_ebus_pi_dev.sv
// Directed bench for ebus_pi_dev; bus answers are queued at issue and checked by a monitor.
module tb_ebus_pi_dev;
   import pi_dev_pkg::*;

   localparam int NSRC = 4;

   localparam logic [35:0] ID_W = 36'o001000000000;
`ifdef VECTOR_INTR_EN
   localparam logic [35:0] VEC_W1 = 36'o020000000102;
   localparam logic [35:0] VEC_W2 = 36'o020000000104;
`else
   localparam logic [35:0] VEC_W1 = 36'o010000000000;
   localparam logic [35:0] VEC_W2 = 36'o010000000000;
`endif

   logic            CLK = 1'b0;
   logic            RESET_L;
   logic [NSRC-1:0] dev_event_i;
   logic            cono_stb_i;
   logic [2:0]      cono_pia_i;
   logic            cono_en_i;
   logic [NSRC-1:0] cono_clr_i;
   logic [NSRC+3:0] coni_o;

   ebus_pi_dev_if bus ();

   ebus_pi_dev #(.NSRC(NSRC), .PHY(4'd8), .VEC_BASE(18'o000100)) dut (
      .CLK         (CLK),
      .RESET_L     (RESET_L),
      .dev_event_i (dev_event_i),
      .cono_stb_i  (cono_stb_i),
      .cono_pia_i  (cono_pia_i),
      .cono_en_i   (cono_en_i),
      .cono_clr_i  (cono_clr_i),
      .coni_o      (coni_o),
      .ebus        (bus)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   logic [35:0] exp_q[$];
   logic        mon_prev = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   // Monitor: each new transfer acknowledge must match the oldest queued answer.
   always @(negedge CLK) begin
      if (RESET_L && bus.ebus_xfer_o && !mon_prev) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_xfer: got data 'h%0h, expected no transfer", bus.ebus_data_o);
         end else begin
            logic [35:0] w;
            w = exp_q.pop_front();
            check("bus_word", 64'(bus.ebus_data_o), 64'(w));
            check("bus_oe", 64'(bus.ebus_data_oe_o), 64'd1);
         end
      end
      mon_prev = RESET_L && bus.ebus_xfer_o;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic cono(input logic [2:0] pia, input logic en, input logic [NSRC-1:0] clr);
      cono_stb_i = 1'b1;
      cono_pia_i = pia;
      cono_en_i  = en;
      cono_clr_i = clr;
      cyc();
      cono_stb_i = 1'b0;
      cono_clr_i = '0;
   endtask

   task automatic pulse_ev(input logic [NSRC-1:0] m);
      dev_event_i = m;
      cyc();
      dev_event_i = '0;
   endtask

   task automatic demand_on(input logic [2:0] fn, input logic [2:0] lvl, input logic [3:0] sel);
      bus.ebus_demand_i = 1'b1;
      bus.ebus_func_i   = fn;
      bus.ebus_lvl_i    = lvl;
      bus.ebus_sel_i    = sel;
   endtask

   task automatic demand_off();
      bus.ebus_demand_i = 1'b0;
      bus.ebus_func_i   = 3'd0;
   endtask

   // Full ID phase at level 3 followed by release.
   task automatic id_cycle();
      exp_q.push_back(ID_W);
      demand_on(FN_ID, 3'd3, 4'd0);
      repeat (3) cyc();
      demand_off();
      cyc();
   endtask

   task automatic ignored(input string name, input logic [2:0] fn, input logic [2:0] lvl,
                          input logic [3:0] sel);
      demand_on(fn, lvl, sel);
      repeat (3) cyc();
      check(name, 64'(bus.ebus_data_oe_o), 64'd0);
      demand_off();
      cyc();
   endtask

   initial begin
      RESET_L     = 1'b0;
      dev_event_i = '0;
      cono_stb_i  = 1'b0;
      cono_pia_i  = 3'd0;
      cono_en_i   = 1'b0;
      cono_clr_i  = '0;
      bus.ebus_demand_i = 1'b0;
      bus.ebus_func_i   = 3'd0;
      bus.ebus_lvl_i    = 3'd0;
      bus.ebus_sel_i    = 4'd0;
      repeat (2) cyc();
      check("rst_coni", 64'(coni_o), 64'h00);
      check("rst_pi", 64'(bus.ebus_pi_o), 64'h0);
      check("rst_oe", 64'(bus.ebus_data_oe_o), 64'd0);
      check("rst_xfer", 64'(bus.ebus_xfer_o), 64'd0);
      check("rst_data", 64'(bus.ebus_data_o), 64'd0);
      RESET_L = 1'b1;
      cyc();

      // Request line follows pending by one cycle.
      cono(3'd3, 1'b1, '0);
      check("cono_load", 64'(coni_o), 64'h0B);
      pulse_ev(4'b0100);
      check("ev2_pending", 64'(coni_o), 64'h4B);
      check("pi_lag", 64'(bus.ebus_pi_o), 64'h0);
      cyc();
      check("pi_line3", 64'(bus.ebus_pi_o), 64'(7'b0010000));

      // ID phase: latency, hold, simultaneous release.
      exp_q.push_back(ID_W);
      demand_on(FN_ID, 3'd3, 4'd0);
      cyc();
      check("id_latency", 64'(bus.ebus_data_oe_o), 64'd0);
      repeat (3) cyc();
      check("id_hold_oe", 64'(bus.ebus_data_oe_o), 64'd1);
      demand_off();
      cyc();
      check("id_rel_oe", 64'(bus.ebus_data_oe_o), 64'd0);
      check("id_rel_xfer", 64'(bus.ebus_xfer_o), 64'd0);
      check("id_rel_data", 64'(bus.ebus_data_o), 64'd0);
      check("id_no_retire", 64'(coni_o), 64'h4B);

      ignored("lvl5_ignored", FN_ID, 3'd5, 4'd0);
      ignored("sel_mismatch", FN_VEC, 3'd0, 4'd5);
      ignored("func_ignored", 3'o3, 3'd3, 4'd8);

      // Clear source 2, then serve source 1 out of {1,3}.
      cono(3'd3, 1'b1, 4'b0100);
      check("cono_clr", 64'(coni_o), 64'h0B);
      cyc();
      check("pi_drop_empty", 64'(bus.ebus_pi_o), 64'h0);
      pulse_ev(4'b1010);
      cyc();
      check("ev13_pending", 64'(coni_o), 64'hAB);
      check("pi_line3_again", 64'(bus.ebus_pi_o), 64'(7'b0010000));
      id_cycle();
      exp_q.push_back(VEC_W1);
      demand_on(FN_VEC, 3'd0, 4'd8);
      repeat (3) cyc();
      demand_off();
      cyc();
      check("retire_src1", 64'(coni_o), 64'h8B);
      cyc();
      check("line_held", 64'(bus.ebus_pi_o), 64'(7'b0010000));

      // Set and clear of the same bit in one cycle: set wins.
      dev_event_i = 4'b0001;
      cono(3'd3, 1'b1, 4'b0001);
      dev_event_i = '0;
      check("set_wins", 64'(coni_o), 64'h9B);
      cono(3'd3, 1'b1, 4'b1111);
      check("clr_all", 64'(coni_o), 64'h0B);

      // Asynchronous reset while driving a VECTOR answer.
      pulse_ev(4'b0010);
      id_cycle();
      exp_q.push_back(VEC_W1);
      demand_on(FN_VEC, 3'd0, 4'd8);
      repeat (2) cyc();
      check("vec_oe_before_rst", 64'(bus.ebus_data_oe_o), 64'd1);
      @(negedge CLK);
      #2;
      RESET_L = 1'b0;
      #1;
      check("arst_oe", 64'(bus.ebus_data_oe_o), 64'd0);
      check("arst_xfer", 64'(bus.ebus_xfer_o), 64'd0);
      check("arst_data", 64'(bus.ebus_data_o), 64'd0);
      check("arst_pi", 64'(bus.ebus_pi_o), 64'h0);
      demand_off();
      @(posedge CLK);
      #1;
      RESET_L = 1'b1;
      cyc();
      check("post_rst_coni", 64'(coni_o), 64'h00);
      check("post_rst_state", 64'(dut.r_state), 64'(S_IDLE));
      ignored("vec_no_snapshot", FN_VEC, 3'd0, 4'd8);

      // PIA cleared while releasing a VECTOR cycle: line drops, retire still happens.
      cono(3'd3, 1'b1, '0);
      pulse_ev(4'b0100);
      cyc();
      check("pi_line3_rearm", 64'(bus.ebus_pi_o), 64'(7'b0010000));
      id_cycle();
      exp_q.push_back(VEC_W2);
      demand_on(FN_VEC, 3'd0, 4'd8);
      repeat (2) cyc();
      cono(3'd0, 1'b1, '0);
      cyc();
      check("pia0_line_drop", 64'(bus.ebus_pi_o), 64'h0);
      check("rel_still_held", 64'(bus.ebus_data_oe_o), 64'd1);
      demand_off();
      cyc();
      check("rel_done_oe", 64'(bus.ebus_data_oe_o), 64'd0);
      check("retire_src2", 64'(coni_o), 64'h08);

      repeat (3) cyc();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
